// File: rtl/demux_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// demux_frame_sequencer_if
//   Serial bit stream handshake between a source and the frame sequencer.
//   Signals:
//     din        serial data bit          (source -> sequencer)
//     din_valid  din carries a valid bit  (source -> sequencer)
//     din_ready  sequencer takes din      (sequencer -> source)
//   Modports:
//     master  the serial source
//     slave   the sequencer
// -----------------------------------------------------------------------------
interface demux_frame_sequencer_if;
   logic din;
   logic din_valid;
   logic din_ready;

   modport master (
      output din,
      output din_valid,
      input  din_ready
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready
   );
endinterface

// File: rtl/demux_frame_sequencer.sv
// -----------------------------------------------------------------------------
// demux_frame_sequencer
//   Drives a 1-to-2**SEL_W bit demultiplexer from a serial bit stream. Bit k
//   of a frame goes to channel first_ch+k (mod N_CH). A shadow copy of every
//   channel is kept and copied to frame_q as a coherent snapshot when the
//   frame's last bit is accepted.
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     start          frame start request, sampled in IDLE only
//     first_ch       first channel of the frame, used on an accepted start
//     last_ch        last channel of the frame, latched on an accepted start
//     abort          cancel the frame in progress (RUN only)
//     s_if           serial input handshake (din/din_valid/din_ready)
//     dmx_in         data bit to the demuxer
//     dmx_sel        channel select to the demuxer
//     dmx_strobe     dmx_in/dmx_sel carry a fresh write this cycle
//     frame_q        snapshot of the last completed frame
//     busy           sequencer not idle
//     done           one-cycle pulse, frame_q has just been updated
//     err            one-cycle pulse, start request rejected while busy
// -----------------------------------------------------------------------------
module demux_frame_sequencer #(
   parameter int SEL_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SEL_W-1:0]      first_ch,
   input  logic [SEL_W-1:0]      last_ch,
   input  logic                  abort,
   demux_frame_sequencer_if.slave s_if,
   output logic                  dmx_in,
   output logic [SEL_W-1:0]      dmx_sel,
   output logic                  dmx_strobe,
   output logic [2**SEL_W-1:0]   frame_q,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int N_CH = 2**SEL_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [SEL_W-1:0] cur_q,     cur_d;
   logic [SEL_W-1:0] last_q,    last_d;
   logic [N_CH-1:0]  shadow_q,  shadow_d;
   logic [N_CH-1:0]  frame_q_q, frame_d;
   logic             dmx_in_q,  dmx_in_d;
   logic [SEL_W-1:0] dmx_sel_q, dmx_sel_d;
   logic             strobe_q,  strobe_d;
   logic             err_q,     err_d;

   logic ready;
   logic xfer;

   // abort suppresses ready so it always wins over a simultaneous din_valid
   assign ready          = (state_q == ST_RUN) && !abort;
   assign xfer           = ready && s_if.din_valid;
   assign s_if.din_ready = ready;

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      last_d    = last_q;
      shadow_d  = shadow_q;
      frame_d   = frame_q_q;
      dmx_in_d  = dmx_in_q;
      dmx_sel_d = dmx_sel_q;
      strobe_d  = 1'b0;
      err_d     = start && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cur_d   = first_ch;
               last_d  = last_ch;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               dmx_in_d        = s_if.din;
               dmx_sel_d       = cur_q;
               strobe_d        = 1'b1;
               shadow_d[cur_q] = s_if.din;
               cur_d           = SEL_W'(cur_q + 1'b1);
               if (cur_q == last_q) begin
                  // snapshot includes the bit written on this same edge
                  frame_d = shadow_d;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         last_q    <= '0;
         shadow_q  <= '0;
         frame_q_q <= '0;
         dmx_in_q  <= 1'b0;
         dmx_sel_q <= '0;
         strobe_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         last_q    <= last_d;
         shadow_q  <= shadow_d;
         frame_q_q <= frame_d;
         dmx_in_q  <= dmx_in_d;
         dmx_sel_q <= dmx_sel_d;
         strobe_q  <= strobe_d;
         err_q     <= err_d;
      end
   end

   assign dmx_in     = dmx_in_q;
   assign dmx_sel    = dmx_sel_q;
   assign dmx_strobe = strobe_q;
   assign frame_q    = frame_q_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;

endmodule
